// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bit-phase constants for the I2C writer
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK1  = 3'd3,
        DATA  = 3'd4,
        ACK2  = 3'd5,
        STOP  = 3'd6,
        DONE  = 3'd7
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_qtr_tick.sv
// i2c_qtr_tick: one-cycle tick every QTR clocks, marking quarter-bit boundaries
module i2c_qtr_tick #(
    parameter int unsigned QTR = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int W = (QTR > 1) ? $clog2(QTR) : 1;

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == W'(QTR - 1));

    // free-running divider, wraps on each tick
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= tick_o ? '0 : cnt_q + 1'b1;

endmodule

// File: rtl/i2c_master_writer.sv
// i2c_master_writer: issues a single I2C write (addr + one byte) after reset, then parks the bus
module i2c_master_writer
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter logic [7:0]  WR_DATA    = 8'hAA,
    parameter int unsigned QTR        = 1
) (
    input  logic clk,
    input  logic reset,
    output logic i2c_scl,
    output logic i2c_sda
);

    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, WRITE};

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        tick;

    i2c_qtr_tick #(.QTR(QTR)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    // advance one quarter per tick; byte states repeat their quarters for 8 bits
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (tick && state_q == IDLE) begin
            state_d = START;
            phase_d = Q0;
        end else if (tick && state_q != DONE) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == Q3) begin
                unique case (state_q)
                    START: begin
                        state_d = ADDR;
                        bit_d   = 3'd7;
                        shift_d = ADDR_BYTE;
                    end
                    ADDR, DATA: begin
                        if (bit_q == 3'd0) begin
                            state_d = (state_q == ADDR) ? ACK1 : ACK2;
                        end else begin
                            bit_d   = bit_q - 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                    ACK1: begin
                        state_d = DATA;
                        bit_d   = 3'd7;
                        shift_d = WR_DATA;
                    end
                    ACK2:    state_d = STOP;
                    STOP:    state_d = DONE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // bus levels for the upcoming quarter, registered so the pins come straight from flops
    always_comb begin
        scl_d = (state_d == IDLE || state_d == DONE || state_d == START) ? 1'b1 : phase_d[1];
        unique case (state_d)
            START:      sda_d = (phase_d < Q2);
            ADDR, DATA: sda_d = shift_d[7];
            STOP:       sda_d = (phase_d == Q3);
            default:    sda_d = 1'b1;
        endcase
    end

    // state, counters and output flops; reset releases the bus at once
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= Q0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end

    assign i2c_scl = scl_q;
    assign i2c_sda = sda_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// tb_i2c_master_writer: decodes the bus of two writer instances and scores the bits against expected frames
module tb_i2c_master_writer;

    logic clk;
    logic rst_a, rst_b;
    logic scl_a, sda_a, scl_b, sda_b;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    int start_e, stop_e, fall1, rise1, fall2, viol, last_edge, nbits;

    i2c_master_writer dut_a (
        .clk     (clk),
        .reset   (rst_a),
        .i2c_scl (scl_a),
        .i2c_sda (sda_a)
    );

    i2c_master_writer #(.SLAVE_ADDR(7'h3C), .WR_DATA(8'h5A), .QTR(3)) dut_b (
        .clk     (clk),
        .reset   (rst_b),
        .i2c_scl (scl_b),
        .i2c_sda (sda_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_frame(input logic [7:0] a, input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_q.push_back(a[i]);
        exp_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
    endtask

    task automatic observe(input bit which, input int ncyc);
        logic ps, pd, cs, cd;
        bit   eb;
        start_e = -1; stop_e = -1; fall1 = -1; rise1 = -1; fall2 = -1;
        viol = 0; last_edge = -1; nbits = 0;
        ps = 1'b1; pd = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            cs = which ? scl_b : scl_a;
            cd = which ? sda_b : sda_a;
            if (cs !== ps || cd !== pd) last_edge = k;
            if (ps && cs && pd && !cd) begin
                if (start_e < 0) start_e = k; else viol++;
            end else if (ps && cs && !pd && cd) begin
                if (start_e >= 0 && stop_e < 0) stop_e = k; else viol++;
            end
            if (ps && !cs) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!ps && cs && nbits < 18) begin
                if (rise1 < 0) rise1 = k;
                nbits++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_bit n=%0d got=%b exp=none", nbits, cd);
                end else begin
                    eb = exp_q.pop_front();
                    if (cd !== eb) begin
                        bad++;
                        $display("FAIL bit%0d dut%0d got=%b exp=%b", nbits, which, cd, eb);
                    end
                end
            end
            ps = cs;
            pd = cd;
        end
    endtask

    task automatic check_frame(input string tag, input int qtr);
        total++;
        if (start_e !== 3 * qtr) begin
            bad++;
            $display("FAIL %s start_edge got=%0d exp=%0d", tag, start_e, 3 * qtr);
        end
        total++;
        if (stop_e !== 80 * qtr) begin
            bad++;
            $display("FAIL %s stop_edge got=%0d exp=%0d", tag, stop_e, 80 * qtr);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL %s sda_while_scl_high got=%0d exp=0", tag, viol);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s missing_bits got=%0d exp=0", tag, exp_q.size());
        end
        total++;
        if (last_edge !== 80 * qtr) begin
            bad++;
            $display("FAIL %s last_bus_change got=%0d exp=%0d", tag, last_edge, 80 * qtr);
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({scl_a, sda_a} !== 2'b11) begin
            bad++;
            $display("FAIL reset_a got=%b exp=11", {scl_a, sda_a});
        end
        total++;
        if ({scl_b, sda_b} !== 2'b11) begin
            bad++;
            $display("FAIL reset_b got=%b exp=11", {scl_b, sda_b});
        end
    endtask

    task automatic test_frame_default;
        exp_q.delete();
        @(negedge clk);
        rst_a = 1'b1;
        push_frame(8'hA0, 8'hAA);
        observe(1'b0, 200);
        check_frame("dflt", 1);
        total++;
        if ({scl_a, sda_a} !== 2'b11) begin
            bad++;
            $display("FAIL dflt_done got=%b exp=11", {scl_a, sda_a});
        end
    endtask

    task automatic test_mid_reset;
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        total++;
        if ({scl_a, sda_a} !== 2'b10) begin
            bad++;
            $display("FAIL q30_level got=%b exp=10", {scl_a, sda_a});
        end
        #2;
        rst_a = 1'b0;
        #1;
        total++;
        if ({scl_a, sda_a} !== 2'b11) begin
            bad++;
            $display("FAIL async_reset got=%b exp=11", {scl_a, sda_a});
        end
        repeat (2) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst_a = 1'b1;
        push_frame(8'hA0, 8'hAA);
        observe(1'b0, 120);
        check_frame("restart", 1);
    endtask

    task automatic test_qtr3;
        exp_q.delete();
        @(negedge clk);
        rst_b = 1'b1;
        push_frame(8'h78, 8'h5A);
        observe(1'b1, 300);
        check_frame("qtr3", 3);
        total++;
        if (rise1 - fall1 !== 6) begin
            bad++;
            $display("FAIL qtr3_scl_low got=%0d exp=6", rise1 - fall1);
        end
        total++;
        if (fall2 - rise1 !== 6) begin
            bad++;
            $display("FAIL qtr3_scl_high got=%0d exp=6", fall2 - rise1);
        end
    endtask

    initial begin
        test_reset();
        test_frame_default();
        test_mid_reset();
        test_qtr3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_writer.md
# i2c_master_writer

Self-contained I2C master that issues exactly one write transaction after reset: START, 7-bit slave address with R/W=0, one ACK slot, one data byte, one ACK slot, then STOP. It then parks the bus idle until the next reset. It has no host-side data interface; address and data are compile-time parameters. It serves as a bring-up and bus-exercise block driving a board-level I2C bus.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit target address.
- `WR_DATA`, default 8'hAA: byte written.
- `QTR`, default 1: clk cycles per quarter bit period, ≥1; one SCL bit = 4·QTR clk cycles.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `i2c_scl` output 1: I2C clock, registered, push-pull.
- `i2c_sda` output 1: I2C data, registered, push-pull; "released" means driven 1.

## Operation
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE. Each bit-level state spans 4 quarters (q0..q3). ADDR and DATA each repeat their quarters for 8 bits, MSB first.
- Address byte = {SLAVE_ADDR, 1'b0} (write).
- IDLE:
  - scl=1, sda=1.
  - Left on the first tick after reset deasserts.
- START:
  - q0,q1: scl=1, sda=1.
  - q2,q3: scl=1, sda=0. SDA falls while SCL is high.
- Data bit (ADDR and DATA):
  - q0: scl=0, sda=bit (SDA changes only while SCL is low).
  - q1: scl=0.
  - q2,q3: scl=1, sda holds.
- ACK1, ACK2:
  - Same SCL pattern as a data bit, sda=1 (released).
  - The ACK is not sampled and a NACK has no effect. The frame always completes.
- STOP:
  - q0,q1: scl=0, sda=0.
  - q2: scl=1, sda=0.
  - q3: scl=1, sda=1. SDA rises while SCL is high.
- DONE:
  - scl=1, sda=1 indefinitely.
  - Terminal state; only reset restarts a frame.
- Internal counters:
  - Quarter tick counter: 0..QTR-1.
  - Phase counter: 0..3.
  - Bit index: 7..0.
  - Shift register holding the current byte.
- Reset mid-frame: both outputs go to 1 immediately, asynchronously. All counters clear. A complete new frame starts after release, with no partial resume.

## Timing
- Reset values: i2c_scl=1, i2c_sda=1, state=IDLE, counters 0.
- With QTR=1, on rising edge k after reset release (k≥1), outputs show frame quarter k-1:
  - Quarters 0-3: START.
  - Quarters 4-35: address bits 7..0.
  - Quarters 36-39: ACK1.
  - Quarters 40-71: data bits.
  - Quarters 72-75: ACK2.
  - Quarters 76-79: STOP.
  - Quarters 80 and later: DONE.
- General QTR: each quarter lasts QTR cycles. Total frame = 80·QTR cycles.
- No glitches: outputs come straight from flops, and SDA never changes in the same quarter SCL rises.

## Structure
- Shared package `i2c_pkg`:
  - State enum.
  - Quarter-phase constants.
  - R/W bit constant (WRITE=0).
- Single module; no sub-module required. An optional `i2c_qtr_tick` divider producing a one-cycle tick every QTR clocks is natural if reused.

## Test plan
- Defaults, reset low 20 ns then high (10 ns clk): outputs 1/1 during reset. First SDA fall occurs with SCL=1 at quarter 2 → START detected.
- Sample SDA on each SCL rising edge after START: first 8 bits = 0xA0, 9th = 1, next 8 = 0xAA, 18th = 1.
- STOP check: SDA rises while SCL=1 at quarter 79. Afterwards scl=sda=1 held for ≥100 cycles with no further edges.
- Protocol monitor: SDA never toggles while SCL=1 except at START and STOP. Total frame 80 cycles.
- Reset asserted at quarter 30 (mid-address): outputs 1/1 asynchronously within the same cycle. After release, a full frame repeats from START with the address again 0xA0.
- QTR=3, SLAVE_ADDR=7'h3C, WR_DATA=8'h5A: bytes 0x78 and 0x5A decoded, SCL high/low each 6 cycles, frame 240 cycles.
